// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - run enable and sync/timing outputs of the VGA timing stage
interface vga_sync_gen_if #(
    parameter int CW = 10
) ();
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          pix_tick;
    logic          frame_start;

    modport master (
        input  en,
        output hsync, vsync, video_on, pixel_x, pixel_y, pix_tick, frame_start
    );

    modport slave (
        output en,
        input  hsync, vsync, video_on, pixel_x, pixel_y, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-clock divider, h/v counters and registered sync decode
module vga_sync_gen #(
    parameter int PIX_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vif
);
    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = H_VIS + H_FP + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = V_VIS + V_FP + V_SYNC - 1;
    localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic          SYNC_ACT = SYNC_POL;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          pix_tick_q, pix_tick_d;
    logic          frame_start_q, frame_start_d;
    logic          tick;

    always_comb begin
        tick          = vif.en && (div_cnt_q == DIV_LAST);
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pix_tick_d    = 1'b0;
        frame_start_d = 1'b0;

        if (vif.en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
                if (h_cnt_q == H_LAST) begin
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
                end
            end

            // Outputs decode the pre-edge counters, so they trail the counters by one clk.
            pix_tick_d    = tick;
            pixel_x_d     = h_cnt_q;
            pixel_y_d     = v_cnt_q;
            video_on_d    = (h_cnt_q < CW'(H_VIS)) && (v_cnt_q < CW'(V_VIS));
            hsync_d       = (h_cnt_q >= CW'(HS_START) && h_cnt_q <= CW'(HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            vsync_d       = (v_cnt_q >= CW'(VS_START) && v_cnt_q <= CW'(VS_END)) ? SYNC_ACT : ~SYNC_ACT;
            frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.video_on    = video_on_q;
    assign vif.pixel_x     = pixel_x_q;
    assign vif.pixel_y     = pixel_y_q;
    assign vif.pix_tick    = pix_tick_q;
    assign vif.frame_start = frame_start_q;
endmodule
